alu_pipe_machine: RTL



---
 rtl/alu_pipe_machine.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_pipe_machine.sv
// Two-stage (read / execute) register-file ALU machine with valid/ready input handshake.
// Define ALU_PIPE_FORWARD_EN to resolve read-after-write hazards by forwarding instead of interlock.
module alu_pipe_machine #(
   parameter  int WIDTH = 8,
   parameter  int NREGS = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_op,
   input  logic             wen,
   input  logic [WIDTH-1:0] wd,
   input  logic             rw,
   input  logic [AW-1:0]    ri_a,
   input  logic [AW-1:0]    ri_b,
   input  logic [AW-1:0]    ri_d,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       flags
);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_NOT = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } op_e;

   logic [WIDTH-1:0] regs_q [NREGS];

   logic             ex_valid_q;
   op_e              ex_op_q;
   logic             ex_wen_q;
   logic [WIDTH-1:0] ex_wd_q;
   logic             ex_rw_q;
   logic [AW-1:0]    ex_rd_q;
   logic [WIDTH-1:0] ex_a_q;
   logic [WIDTH-1:0] ex_b_q;

   logic             out_valid_q;
   logic [WIDTH-1:0] out_q;
   logic [3:0]       flags_q;

   logic [WIDTH-1:0] res_d;
   logic [3:0]       flags_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   dif;
   logic             c_flag;
   logic             v_flag;

   logic             hit_a;
   logic             hit_b;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic             accept;

   // Execute stage: result and flags from the EX registers.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      res_d  = '0;
      c_flag = 1'b0;
      v_flag = 1'b0;
      sum    = {1'b0, ex_a_q} + {1'b0, ex_b_q};
      dif    = {1'b0, ex_a_q} - {1'b0, ex_b_q};
      if (ex_wen_q) begin
         res_d = ex_wd_q;
      end else begin
         case (ex_op_q)
            OP_ADD: begin
               res_d  = sum[WIDTH-1:0];
               c_flag = sum[WIDTH];
               v_flag = (ex_a_q[WIDTH-1] == ex_b_q[WIDTH-1]) && (sum[WIDTH-1] != ex_a_q[WIDTH-1]);
            end
            OP_SUB: begin
               res_d  = dif[WIDTH-1:0];
               c_flag = ~dif[WIDTH];
               v_flag = (ex_a_q[WIDTH-1] != ex_b_q[WIDTH-1]) && (dif[WIDTH-1] != ex_a_q[WIDTH-1]);
            end
            OP_AND: res_d = ex_a_q & ex_b_q;
            OP_OR:  res_d = ex_a_q | ex_b_q;
            OP_XOR: res_d = ex_a_q ^ ex_b_q;
            OP_NOT: res_d = ~ex_a_q;
            OP_SHL: begin
               res_d  = {ex_a_q[WIDTH-2:0], 1'b0};
               c_flag = ex_a_q[WIDTH-1];
            end
            OP_SHR: begin
               res_d  = {1'b0, ex_a_q[WIDTH-1:1]};
               c_flag = ex_a_q[0];
            end
         endcase
      end
      flags_d = {v_flag, c_flag, res_d[WIDTH-1], (res_d == '0)};
   end

   // A pending write-back in EX that targets either source register.
   assign hit_a = ex_valid_q && ex_rw_q && (ex_rd_q == ri_a);
   assign hit_b = ex_valid_q && ex_rw_q && (ex_rd_q == ri_b);

`ifdef ALU_PIPE_FORWARD_EN
   assign rd_a     = hit_a ? res_d : regs_q[ri_a];
   assign rd_b     = hit_b ? res_d : regs_q[ri_b];
   assign in_ready = rst_n;
`else
   assign rd_a     = regs_q[ri_a];
   assign rd_b     = regs_q[ri_b];
   assign in_ready = rst_n && !(hit_a || hit_b);
`endif

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the register file is part of the reset state, so every entry is cleared here.
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         ex_valid_q  <= 1'b0;
         ex_op_q     <= OP_ADD;
         ex_wen_q    <= 1'b0;
         ex_wd_q     <= '0;
         ex_rw_q     <= 1'b0;
         ex_rd_q     <= '0;
         ex_a_q      <= '0;
         ex_b_q      <= '0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         flags_q     <= '0;
      end else begin
         ex_valid_q  <= accept;
         out_valid_q <= ex_valid_q;
         if (accept) begin
            ex_op_q  <= op_e'(alu_op);
            ex_wen_q <= wen;
            ex_wd_q  <= wd;
            ex_rw_q  <= rw;
            ex_rd_q  <= ri_d;
            ex_a_q   <= rd_a;
            ex_b_q   <= rd_b;
         end
         if (ex_valid_q) begin
            out_q   <= res_d;
            flags_q <= flags_d;
            if (ex_rw_q) regs_q[ex_rd_q] <= res_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign flags     = flags_q;

endmodule
